// File: rtl/mux_sel_skid_pkg.sv
// Shared types for the registered select stage.
// State encoding of the two-entry skid buffer.
package mux_sel_skid_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N:1 select with range check.
// An out-of-range index yields a zero word and err=1.
module mux_sel_comb
    import mux_sel_skid_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic [SEL_BITS-1:0]             i_sel,
    input  logic [NUM_INPUTS*DATA_BITS-1:0] i_data,
    output logic [DATA_BITS-1:0]            o_data,
    output logic                            o_err
);

    logic w_err;

    assign w_err = (int'(i_sel) >= NUM_INPUTS);
    assign o_err = w_err;

    // Pick the indexed source; default zero covers out-of-range.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (i_sel == SEL_BITS'(k)) begin
                o_data = i_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

endmodule

// File: rtl/mux_sel_skid.sv
// Registered N-way select stage with valid/ready handshake
// and a two-entry skid buffer (main drives outputs, skid absorbs).
module mux_sel_skid
    import mux_sel_skid_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_BITS-1:0]             in_sel,
    input  logic [NUM_INPUTS*DATA_BITS-1:0] in_data,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_BITS-1:0]            out_data,
    output logic [SEL_BITS-1:0]             out_sel,
    output logic                            sel_err
);

    typedef struct packed {
        logic                 err;
        logic [SEL_BITS-1:0]  sel;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    skid_state_t r_state;
    skid_state_t w_state_nxt;

    entry_t r_main;
    entry_t r_skid;
    entry_t w_new;

    logic [DATA_BITS-1:0] w_mux_data;
    logic                 w_mux_err;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_skid_to_main;

    mux_sel_comb #(
        .DATA_BITS  (DATA_BITS),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_BITS   (SEL_BITS)
    ) u_sel (
        .i_sel  (in_sel),
        .i_data (in_data),
        .o_data (w_mux_data),
        .o_err  (w_mux_err)
    );

    assign w_new = '{err: w_mux_err, sel: in_sel, data: w_mux_data};

    // Handshake decoded from the state register only.
    assign in_ready   = (r_state != S_TWO);
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    assign out_data = r_main.data;
    assign out_sel  = r_main.sel;
    assign sel_err  = r_main.err;

    // Next state and register-load controls; flush overrides all.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = S_ONE;
                        w_load_main = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt    = S_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry registers; main clears on reset so outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_new;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_skid.sv
// Directed bench for mux_sel_skid (4-input and 3-input instances).
// Checks at 1 time unit after each rising edge.
module tb_mux_sel_skid;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [1:0]    out_sel;
    logic          sel_err;

    logic          in_valid3;
    logic          in_ready3;
    logic [1:0]    in_sel3;
    logic [95:0]   in_data3;
    logic          out_valid3;
    logic          out_ready3;
    logic [31:0]   out_data3;
    logic [1:0]    out_sel3;
    logic          sel_err3;

    int errors = 0;
    int checks = 0;

    mux_sel_skid #(.DATA_BITS(DW), .NUM_INPUTS(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .sel_err   (sel_err)
    );

    mux_sel_skid #(.DATA_BITS(DW), .NUM_INPUTS(3)) u3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_sel    (in_sel3),
        .in_data   (in_data3),
        .flush     (flush),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .sel_err   (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] w);
        // Put w on the selected source, distinct junk on the others.
        in_sel  = s;
        in_data = {32'h3333_0003, 32'h2222_0002,
                   32'h1111_0001, 32'h0000_0F00};
        in_data[s*32 +: 32] = w;
    endtask

    logic [31:0] w_exp;

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        in_sel3    = '0;
        in_data3   = '0;
        out_ready3 = 1'b0;

        // Reset state, held in reset.
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;

        // First word: sel 2 = DEADBEEF.
        drive(2'd2, 32'hDEAD_BEEF);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 32'hDEAD_BEEF);
        chk("first_sel", out_sel, 2);
        chk("first_err", sel_err, 0);
        in_valid = 1'b0;
        step();
        chk("first_drain", out_valid, 0);

        // Stream 8 words, out_ready high, no bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(2'(i % 4), 32'hA000_0000 + 32'(i * 16 + (i % 4)));
            in_valid = 1'b1;
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data,
                32'hA000_0000 + 32'(i * 16 + (i % 4)));
            chk("stream_sel", out_sel, 64'(i % 4));
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", out_valid, 0);

        // Back-pressure: A, B, C with out_ready low.
        out_ready = 1'b0;
        drive(2'd1, 32'hAAAA_0001);
        in_valid = 1'b1;
        step();
        chk("bp_a_data", out_data, 32'hAAAA_0001);
        chk("bp_a_ready", in_ready, 1);
        drive(2'd3, 32'hBBBB_0003);
        step();
        chk("bp_b_hold", out_data, 32'hAAAA_0001);
        chk("bp_b_sel", out_sel, 1);
        chk("bp_b_ready", in_ready, 0);
        drive(2'd0, 32'hCCCC_0000);
        step();
        chk("bp_c_hold", out_data, 32'hAAAA_0001);
        chk("bp_c_valid", out_valid, 1);
        chk("bp_c_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data, 32'hBBBB_0003);
        chk("bp_out_b_sel", out_sel, 3);
        chk("bp_ready_up", in_ready, 1);
        step();
        chk("bp_out_c", out_data, 32'hCCCC_0000);
        chk("bp_out_c_sel", out_sel, 0);
        in_valid = 1'b0;
        step();
        chk("bp_drain", out_valid, 0);

        // Out-of-range select on the 3-input instance.
        in_data3   = {32'h3C3C_0002, 32'h3C3C_0001, 32'h3C3C_0000};
        in_sel3    = 2'd3;
        in_valid3  = 1'b1;
        out_ready3 = 1'b1;
        step();
        chk("oor_valid", out_valid3, 1);
        chk("oor_data", out_data3, 0);
        chk("oor_err", sel_err3, 1);
        chk("oor_sel", out_sel3, 3);
        in_sel3 = 2'd2;
        step();
        chk("n3_data", out_data3, 32'h3C3C_0002);
        chk("n3_err", sel_err3, 0);
        in_valid3 = 1'b0;

        // Flush in state TWO together with an incoming word.
        out_ready = 1'b0;
        drive(2'd0, 32'hD0D0_0000);
        in_valid = 1'b1;
        step();
        drive(2'd1, 32'hE0E0_0001);
        step();
        chk("fl_two_ready", in_ready, 0);
        drive(2'd2, 32'hF0F0_0002);
        flush = 1'b1;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_nothing", out_valid, 0);
        drive(2'd3, 32'h6060_0003);
        in_valid = 1'b1;
        step();
        chk("fl_after", out_data, 32'h6060_0003);
        chk("fl_after_v", out_valid, 1);
        in_valid = 1'b0;
        step();

        // Asynchronous reset between edges.
        drive(2'd1, 32'h4848_0001);
        in_valid = 1'b1;
        step();
        chk("ar_pre", out_data, 32'h4848_0001);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(2'd2, 32'h5A5A_0002);
        step();
        chk("ar_resume", out_data, 32'h5A5A_0002);
        chk("ar_resume_sel", out_sel, 2);
        in_valid = 1'b0;
        step();
        chk("ar_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
